// File: rtl/sm_accumulator.sv
// Streaming sign-magnitude frame accumulator.
// Sums a programmable-length frame of sign-magnitude samples with saturation and a sticky overflow flag.
module sm_accumulator #(
    parameter int unsigned WIDTH     = 15,
    parameter int unsigned ACC_WIDTH = 20,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 out_sat,
    output logic                 busy
);

    localparam int unsigned MW = ACC_WIDTH - 1;  // accumulator magnitude width
    localparam int unsigned IW = WIDTH - 1;      // sample magnitude width
    localparam int unsigned SW = MW + 1;         // magnitude sum width incl. carry

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic                 acc_sign, acc_sign_nxt;
    logic [MW-1:0]        acc_mag, acc_mag_nxt;
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
    logic                 sat, sat_nxt;

    logic                 in_sign;
    logic [MW-1:0]        in_mag;
    logic [SW-1:0]        mag_sum;
    logic                 add_sign;
    logic [MW-1:0]        add_mag;
    logic                 add_sat;

    // Sign-magnitude add of the current sample into the accumulator, clamping on carry-out.
    always_comb begin
        in_mag   = MW'(in_data[IW-1:0]);
        in_sign  = in_data[WIDTH-1] && (in_mag != '0);
        mag_sum  = SW'(acc_mag) + SW'(in_mag);
        add_sign = acc_sign;
        add_mag  = acc_mag;
        add_sat  = 1'b0;
        if (in_sign == acc_sign) begin
            if (mag_sum[MW]) begin
                add_mag = '1;
                add_sat = 1'b1;
            end else begin
                add_mag = mag_sum[MW-1:0];
            end
        end else if (acc_mag >= in_mag) begin
            add_mag = acc_mag - in_mag;
        end else begin
            add_mag  = in_mag - acc_mag;
            add_sign = in_sign;
        end
        if (add_mag == '0) begin
            add_sign = 1'b0;
        end
    end

    always_comb begin
        state_nxt    = state;
        acc_sign_nxt = acc_sign;
        acc_mag_nxt  = acc_mag;
        cnt_nxt      = cnt;
        sat_nxt      = sat;
        case (state)
            IDLE: begin
                if (start) begin
                    acc_sign_nxt = 1'b0;
                    acc_mag_nxt  = '0;
                    sat_nxt      = 1'b0;
                    cnt_nxt      = len;
                    state_nxt    = (len != '0) ? ACC : DONE;
                end
            end
            ACC: begin
                if (in_valid && in_ready) begin
                    acc_sign_nxt = add_sign;
                    acc_mag_nxt  = add_mag;
                    sat_nxt      = sat | add_sat;
                    cnt_nxt      = cnt - CNT_WIDTH'(1);
                    if (cnt == CNT_WIDTH'(1)) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake and status flags are registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc_sign  <= 1'b0;
            acc_mag   <= '0;
            cnt       <= '0;
            sat       <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            acc_sign  <= acc_sign_nxt;
            acc_mag   <= acc_mag_nxt;
            cnt       <= cnt_nxt;
            sat       <= sat_nxt;
            in_ready  <= (state_nxt == ACC);
            out_valid <= (state_nxt == DONE);
            busy      <= (state_nxt != IDLE);
        end
    end

    assign out_data = {acc_sign, acc_mag};
    assign out_sat  = sat;

endmodule

// File: tb/tb_sm_accumulator.sv
// Scoreboard bench for sm_accumulator: driver pushes model results, negedge monitor pops and compares.
module tb_sm_accumulator;

    localparam int unsigned W    = 15;
    localparam int unsigned AW   = 20;
    localparam int unsigned CW   = 8;
    localparam int          MAXM = (1 << (AW - 1)) - 1;

    typedef logic [W-1:0] sq_t[$];

    logic          clk;
    logic          rst;
    logic          start;
    logic [CW-1:0] len;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_data;
    logic          out_sat;
    logic          busy;

    int total = 0;
    int bad   = 0;

    logic [AW:0] exp_q[$];  // {sat, sign, magnitude}

    sm_accumulator #(.WIDTH(W), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sat(out_sat), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [W-1:0] sm(input int v);
        int a;
        a = (v < 0) ? -v : v;
        return {v < 0, (W-1)'(a)};
    endfunction

    // Reference: signed integer running sum with symmetric clamping.
    function automatic logic [AW:0] model(input sq_t s);
        int acc = 0;
        logic st = 1'b0;
        int a;
        foreach (s[i]) begin
            int m;
            m = int'(s[i][W-2:0]);
            acc += s[i][W-1] ? -m : m;
            if (acc > MAXM) begin acc = MAXM; st = 1'b1; end
            if (acc < -MAXM) begin acc = -MAXM; st = 1'b1; end
        end
        a = (acc < 0) ? -acc : acc;
        return {st, acc < 0, (AW-1)'(a)};
    endfunction

    // Monitor: compare on handshake, check stability while stalled.
    always @(negedge clk) begin
        logic [AW:0] e;
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 32'(out_valid), 32'(0));
            end else if (out_ready) begin
                e = exp_q.pop_front();
                chk("out_data", 32'(out_data), 32'(e[AW-1:0]));
                chk("out_sat", 32'(out_sat), 32'(e[AW]));
            end else begin
                e = exp_q[0];
                chk("hold_data", 32'(out_data), 32'(e[AW-1:0]));
                chk("hold_sat", 32'(out_sat), 32'(e[AW]));
            end
        end
    end

    // mode: 0 always valid, 1 alternating 1,0,..., 2 random gaps
    task automatic run_frame(input sq_t s, input int mode, input int hold);
        int n;
        int idx;
        int cyc;
        logic v;
        logic [AW:0] e;
        n   = s.size();
        e   = model(s);
        idx = 0;
        cyc = 0;
        start = 1'b1;
        len   = CW'(n);
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_up", 32'(busy), 32'(1));
        if (n > 0) chk("in_ready_up", 32'(in_ready), 32'(1));
        while (idx < n && cyc < 1000) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(1) == 1);
            endcase
            in_valid = v;
            in_data  = v ? s[idx] : W'($urandom);
            start    = ($urandom_range(3) == 0);
            len      = CW'($urandom);
            @(posedge clk); #1;
            cyc++;
            if (v) idx++;
            if (idx < n) begin
                chk("in_ready_mid", 32'(in_ready), 32'(1));
                chk("no_early_out", 32'(out_valid), 32'(0));
            end
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (idx < n) chk("sample_timeout", 32'(idx), 32'(n));
        exp_q.push_back(e);
        chk("out_valid_latency", 32'(out_valid), 32'(1));
        chk("in_ready_done", 32'(in_ready), 32'(0));
        repeat (hold) begin
            start = ($urandom_range(1) == 1);
            len   = CW'($urandom);
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("held_valid", 32'(out_valid), 32'(1));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("idle_after", 32'(busy), 32'(0));
        chk("out_valid_drop", 32'(out_valid), 32'(0));
    endtask

    task automatic chk_reset_outputs();
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_data", 32'(out_data), 32'(0));
        chk("rst_out_sat", 32'(out_sat), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
    endtask

    initial begin
        sq_t q;
        rst       = 1'b1;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs();
        rst = 1'b0;
        @(posedge clk); #1;

        q = '{sm(100), sm(-30), sm(-70)};             run_frame(q, 0, 0);
        q = '{sm(-500), sm(200)};                     run_frame(q, 0, 0);
        q = '{15'h4000};                              run_frame(q, 0, 1);
        q = {};
        repeat (40) q.push_back(sm(16383));           run_frame(q, 0, 0);
        q = '{sm(5)};                                 run_frame(q, 0, 0);
        q = {};
        repeat (40) q.push_back(sm(-16383));          run_frame(q, 2, 2);
        q = '{sm(7), sm(8)};                          run_frame(q, 1, 5);
        q = {};                                       run_frame(q, 0, 0);

        // Abort a frame with reset after two of four samples.
        start = 1'b1;
        len   = CW'(4);
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = sm(3);
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_reset_outputs();
        q = '{sm(-9)};                                run_frame(q, 0, 0);

        repeat (30) begin
            int n;
            n = $urandom_range(20);
            q = {};
            repeat (n) begin
                int m;
                m = ($urandom_range(3) == 0) ? 16383 : $urandom_range(16383);
                q.push_back({($urandom_range(1) == 1), (W-1)'(m)});
            end
            run_frame(q, 2, $urandom_range(4));
        end

        @(posedge clk); #1;
        chk("queue_empty", 32'(exp_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
